fetch_queue_ctrl: RTL and testbench

FETCH_QUEUE_CTRL -- requirements
Module: fetch_queue_ctrl

---
 rtl/fetch_queue_ctrl_if.sv | 29 ++
 rtl/fetch_queue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fetch_queue_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_ctrl_if.sv
// Fetch-side and decode-side signals of the instruction byte queue.
// The queue controller takes the master modport; memory and decoder models take the slave modport.
interface fetch_queue_ctrl_if;
    logic          fetch_req;
    logic [63:0]   fetch_addr;
    logic          fetch_gnt;
    logic          resp_valid;
    logic [63:0]   resp_data;
    logic [0:119]  window;
    logic [4:0]    window_bytes;
    logic [63:0]   decode_pc;
    logic          consume_valid;
    logic [3:0]    consume_bytes;
    logic          redirect_valid;
    logic [63:0]   redirect_pc;
    logic          consume_err;

    modport master (
        output fetch_req, fetch_addr, window, window_bytes, decode_pc, consume_err,
        input  fetch_gnt, resp_valid, resp_data, consume_valid, consume_bytes,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  fetch_req, fetch_addr, window, window_bytes, decode_pc, consume_err,
        output fetch_gnt, resp_valid, resp_data, consume_valid, consume_bytes,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// Instruction byte queue between an 8-byte memory port and a variable-length decoder.
// Fetches aligned doublewords, trims the redirect offset, and exposes a 15-byte decode window.
module fetch_queue_ctrl #(
    parameter int          BUF_BYTES = 32,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_queue_ctrl_if.master bus
);
    localparam int PW = $clog2(BUF_BYTES);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // A new fetch is issued only if a full doubleword still fits.
    localparam logic [CW-1:0] FILL_LIMIT = CW'(BUF_BYTES - 8);

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [63:0]   decode_pc_reg, decode_pc_next;
    logic [63:0]   fetch_addr_reg, fetch_addr_next;
    logic          first_reg, first_next;
    logic [2:0]    drop_reg, drop_next;
    logic          consume_err_reg, consume_err_next;

    logic [7:0]    buf_mem [BUF_BYTES];

    logic [4:0]    win_cnt;
    logic [2:0]    drop_eff;
    logic [3:0]    fill_bytes;
    logic          fill_en;
    logic          consume_ok;
    logic          consume_bad;
    logic [7:0]    win_byte [15];
    logic [0:119]  window_w;

    always_comb begin
        win_cnt = (count_reg > CW'(15)) ? 5'd15 : 5'(count_reg);
    end

    // Only the first doubleword after reset/redirect carries bytes below decode_pc.
    assign drop_eff    = first_reg ? drop_reg : 3'd0;
    assign fill_bytes  = 4'd8 - {1'b0, drop_eff};
    assign fill_en     = (state_reg == ST_WAIT) && bus.resp_valid && !bus.redirect_valid;
    assign consume_ok  = bus.consume_valid && (bus.consume_bytes != 4'd0) &&
                         ({1'b0, bus.consume_bytes} <= win_cnt);
    assign consume_bad = bus.consume_valid && !consume_ok && !bus.redirect_valid;

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        head_next        = head_reg;
        tail_next        = tail_reg;
        decode_pc_next   = decode_pc_reg;
        fetch_addr_next  = fetch_addr_reg;
        first_next       = first_reg;
        drop_next        = drop_reg;
        consume_err_next = 1'b0;

        if (bus.redirect_valid) begin
            count_next      = '0;
            head_next       = '0;
            tail_next       = '0;
            decode_pc_next  = bus.redirect_pc;
            fetch_addr_next = {bus.redirect_pc[63:3], 3'b000};
            first_next      = 1'b1;
            drop_next       = bus.redirect_pc[2:0];
            // Any request already accepted by memory must have its response swallowed.
            case (state_reg)
                ST_REQ:   state_next = bus.fetch_gnt ? ST_DRAIN : ST_IDLE;
                ST_WAIT,
                ST_DRAIN: state_next = bus.resp_valid ? ST_IDLE : ST_DRAIN;
                default:  state_next = ST_IDLE;
            endcase
        end else begin
            count_next = count_reg
                       + (fill_en    ? CW'(fill_bytes)        : CW'(0))
                       - (consume_ok ? CW'(bus.consume_bytes) : CW'(0));
            if (fill_en) begin
                tail_next       = tail_reg + PW'(fill_bytes);
                fetch_addr_next = fetch_addr_reg + 64'd8;
                first_next      = 1'b0;
            end
            if (consume_ok) begin
                head_next      = head_reg + PW'(bus.consume_bytes);
                decode_pc_next = decode_pc_reg + 64'(bus.consume_bytes);
            end
            consume_err_next = consume_bad;
            case (state_reg)
                ST_IDLE:  if (count_reg <= FILL_LIMIT) state_next = ST_REQ;
                ST_REQ:   if (bus.fetch_gnt)           state_next = ST_WAIT;
                ST_WAIT:  if (bus.resp_valid)          state_next = ST_IDLE;
                ST_DRAIN: if (bus.resp_valid)          state_next = ST_IDLE;
                default:                               state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            count_reg       <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            decode_pc_reg   <= RESET_PC;
            fetch_addr_reg  <= {RESET_PC[63:3], 3'b000};
            first_reg       <= 1'b1;
            drop_reg        <= RESET_PC[2:0];
            consume_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            decode_pc_reg   <= decode_pc_next;
            fetch_addr_reg  <= fetch_addr_next;
            first_reg       <= first_next;
            drop_reg        <= drop_next;
            consume_err_reg <= consume_err_next;
        end
    end

    // Byte storage needs no reset: count gates every byte that reaches the window.
    always_ff @(posedge clk) begin
        if (fill_en && !reset) begin
            for (int k = 0; k < 8; k++) begin
                if (3'(k) >= drop_eff) begin
                    buf_mem[tail_reg + PW'(3'(k) - drop_eff)] <= bus.resp_data[8*k +: 8];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_win
            assign win_byte[gi] = (5'(gi) < win_cnt) ? buf_mem[head_reg + PW'(gi)] : 8'h00;
        end
    endgenerate

    always_comb begin
        window_w = '0;
        for (int i = 0; i < 15; i++) begin
            window_w[8*i +: 8] = win_byte[i];
        end
    end

    assign bus.fetch_req    = (state_reg == ST_REQ);
    assign bus.fetch_addr   = fetch_addr_reg;
    assign bus.window       = window_w;
    assign bus.window_bytes = win_cnt;
    assign bus.decode_pc    = decode_pc_reg;
    assign bus.consume_err  = consume_err_reg;
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl: memory responder plus a byte-stream scoreboard
// that holds the bytes the decoder should see, in order, starting at the expected pc.
module tb_fetch_queue_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_ctrl_if bus();

    fetch_queue_ctrl #(.BUF_BYTES(32), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [7:0]  exp_q[$];
    logic [63:0] exp_pc    = 64'h0;
    logic [63:0] next_addr = 64'h0;
    logic        exp_err   = 1'b0;
    int          epoch     = 0;

    bit          mem_en    = 1'b0;
    bit          hold_resp = 1'b0;
    int          req_age   = 0;
    int          resp_cnt  = 0;
    int          lat_epoch = 0;
    logic [63:0] lat_addr  = 64'h0;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int   wb;
        logic legal;
        bus.fetch_gnt  = 1'b0;
        bus.resp_valid = 1'b0;
        if (resp_cnt > 0) begin
            if (resp_cnt > 1 || !hold_resp) resp_cnt--;
            if (resp_cnt == 0) begin
                bus.resp_valid = 1'b1;
                for (int k = 0; k < 8; k++) bus.resp_data[8*k +: 8] = mem_byte(lat_addr + 64'(k));
            end
        end else if (bus.fetch_req && mem_en) begin
            if (req_age >= 1) begin
                bus.fetch_gnt = 1'b1;
                lat_addr  = bus.fetch_addr;
                lat_epoch = epoch;
                resp_cnt  = 2;
                req_age   = 0;
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
        wb    = (exp_q.size() > 15) ? 15 : exp_q.size();
        legal = bus.consume_valid && (bus.consume_bytes != 4'd0) && (int'(bus.consume_bytes) <= wb);
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            exp_pc    = 64'h0;
            next_addr = 64'h0;
            epoch++;
            exp_err   = 1'b0;
            resp_cnt  = 0;
            req_age   = 0;
        end else if (bus.redirect_valid) begin
            exp_q.delete();
            exp_pc    = bus.redirect_pc;
            next_addr = bus.redirect_pc;
            epoch++;
            exp_err   = 1'b0;
        end else begin
            if (legal) begin
                for (int i = 0; i < int'(bus.consume_bytes); i++) void'(exp_q.pop_front());
                exp_pc = exp_pc + 64'(bus.consume_bytes);
            end
            exp_err = bus.consume_valid && !legal;
            if (bus.resp_valid && lat_epoch == epoch) begin
                for (int k = 0; k < 8; k++) begin
                    if (lat_addr + 64'(k) >= next_addr) exp_q.push_back(mem_byte(lat_addr + 64'(k)));
                end
                next_addr = lat_addr + 64'd8;
            end
        end
        #1;
        if (!reset) chk("consume_err", 128'(bus.consume_err), 128'(exp_err));
        bus.consume_valid  = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic consume(input int n);
        bus.consume_valid = 1'b1;
        bus.consume_bytes = 4'(n);
        tick();
    endtask

    task automatic check_window(input string tag);
        logic [0:119] ew;
        int n;
        n  = (exp_q.size() > 15) ? 15 : exp_q.size();
        ew = '0;
        for (int i = 0; i < n; i++) ew[8*i +: 8] = exp_q[i];
        chk({tag, "/window_bytes"}, 128'(bus.window_bytes), 128'(n));
        chk({tag, "/decode_pc"},    128'(bus.decode_pc),    128'(exp_pc));
        chk({tag, "/window"},       128'(bus.window),       128'(ew));
        $display("step %s: window_bytes=%0d decode_pc=%0h", tag, bus.window_bytes, bus.decode_pc);
    endtask

    task automatic wait_ready();
        int g = 0;
        while (resp_cnt != 1 && g < 20) begin
            tick();
            g++;
        end
        chk("resp_ready", 128'(resp_cnt), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int n;
        reset              = 1'b1;
        bus.fetch_gnt      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_data      = 64'h0;
        bus.consume_bytes  = 4'd0;
        bus.redirect_pc    = 64'h0;
        for (int r = 0; r < 2; r++) begin
            bus.consume_valid  = 1'b1;
            bus.consume_bytes  = 4'd4;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = 64'hDEAD_BEEF;
            tick();
        end
        chk("rst/fetch_req",    128'(bus.fetch_req),    128'(0));
        chk("rst/fetch_addr",   128'(bus.fetch_addr),   128'(0));
        chk("rst/consume_err",  128'(bus.consume_err),  128'(0));
        check_window("reset");
        reset  = 1'b0;
        mem_en = 1'b1;

        // Fill from address 0 until the queue is full.
        g = 0;
        while (exp_q.size() < 32 && g < 100) begin tick(); g++; end
        repeat (10) tick();
        chk("full/fetch_req", 128'(bus.fetch_req), 128'(0));
        chk("full/window_bytes", 128'(bus.window_bytes), 128'(15));
        check_window("full");

        // Steady consumption of 3 bytes; fetch restarts once space for 8 appears.
        mem_en = 1'b0;
        for (int i = 0; i < 3; i++) begin check_window("c3"); consume(3); end
        chk("c3/fetch_hold", 128'(bus.fetch_req), 128'(0));
        tick();
        chk("c3/fetch_resume", 128'(bus.fetch_req), 128'(1));
        mem_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            check_window("wrap");
            if (exp_q.size() >= 3) consume(3);
            else tick();
        end

        // Illegal consumes at window_bytes = 4.
        g = 0;
        while (exp_q.size() < 12 && g < 40) begin tick(); g++; end
        mem_en = 1'b0;
        repeat (8) tick();
        g = 0;
        while (exp_q.size() > 4 && g < 20) begin
            n = exp_q.size() - 4;
            if (n > 15) n = 15;
            consume(n);
            g++;
        end
        chk("err/pre_wb", 128'(bus.window_bytes), 128'(4));
        check_window("pre_err");
        consume(5);
        chk("err/pulse5", 128'(bus.consume_err), 128'(1));
        tick();
        consume(0);
        chk("err/pulse0", 128'(bus.consume_err), 128'(1));
        tick();
        check_window("post_err");

        // Fill and consume in the same cycle, then redirect in the same cycle.
        hold_resp = 1'b1;
        mem_en    = 1'b1;
        wait_ready();
        hold_resp = 1'b0;
        tick();
        check_window("fill12");
        hold_resp = 1'b1;
        consume(2);
        wait_ready();
        chk("fc/at10", 128'(bus.window_bytes), 128'(10));
        hold_resp = 1'b0;
        consume(7);
        chk("fc/count11", 128'(bus.window_bytes), 128'(11));
        check_window("after_fc");
        hold_resp = 1'b1;
        consume(1);
        wait_ready();
        check_window("at10b");
        hold_resp          = 1'b0;
        mem_en             = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2340;
        consume(7);
        chk("fcr/window_bytes", 128'(bus.window_bytes), 128'(0));
        chk("fcr/decode_pc",    128'(bus.decode_pc),    128'(64'h2340));

        // Redirect while idle to an unaligned pc.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h1005;
        tick();
        chk("r1005/fetch_addr", 128'(bus.fetch_addr), 128'(64'h1000));
        chk("r1005/fetch_req",  128'(bus.fetch_req),  128'(0));
        mem_en = 1'b1;
        g = 0;
        while (exp_q.size() == 0 && g < 20) begin tick(); g++; end
        chk("r1005/window_bytes", 128'(bus.window_bytes), 128'(3));
        check_window("r1005");

        // Redirect while a response is outstanding; the late response is stale.
        g = 0;
        while (resp_cnt == 0 && g < 20) begin tick(); g++; end
        chk("stale/granted", 128'(resp_cnt), 128'(2));
        hold_resp          = 1'b1;
        mem_en             = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2A13;
        tick();
        tick();
        hold_resp = 1'b0;
        tick();
        chk("stale/window_bytes", 128'(bus.window_bytes), 128'(0));
        tick();
        chk("stale/fetch_req",  128'(bus.fetch_req),  128'(1));
        chk("stale/fetch_addr", 128'(bus.fetch_addr), 128'(64'h2A10));
        mem_en = 1'b1;
        g = 0;
        while (exp_q.size() == 0 && g < 20) begin tick(); g++; end
        check_window("r2a13");
        consume(2);
        check_window("final");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
